// File: rtl/image_mem_arbiter_if.sv
// Bundle of requester handshakes and image-memory bus signals shared by the
// arbiter (slave view) and the requesters/memory model (master view).
interface image_mem_arbiter_if;
  // Handshake: a requester raises *_req with x/y/sel held stable; the transfer
  // happens in the cycle where *_gnt is high. The matching *_rvalid pulses
  // later with rdata, in grant order; there is no backpressure on read data.
  logic       disp_req;
  logic [7:0] disp_x;
  logic [7:0] disp_y;
  logic [1:0] disp_sel;
  logic       disp_gnt;
  logic       disp_rvalid;
  logic       hist_req;
  logic [7:0] hist_x;
  logic [7:0] hist_y;
  logic [1:0] hist_sel;
  logic       hist_gnt;
  logic       hist_rvalid;
  logic [2:0] rdata;
  logic [7:0] mem_xoff;
  logic [7:0] mem_yoff;
  logic [1:0] mem_sel;
  logic [2:0] mem_pixel;
  logic       settling;

  modport slave (
    input  disp_req, disp_x, disp_y, disp_sel,
    input  hist_req, hist_x, hist_y, hist_sel,
    input  mem_pixel,
    output disp_gnt, disp_rvalid, hist_gnt, hist_rvalid,
    output rdata, mem_xoff, mem_yoff, mem_sel, settling
  );

  modport master (
    output disp_req, disp_x, disp_y, disp_sel,
    output hist_req, hist_x, hist_y, hist_sel,
    output mem_pixel,
    input  disp_gnt, disp_rvalid, hist_gnt, hist_rvalid,
    input  rdata, mem_xoff, mem_yoff, mem_sel, settling
  );
endinterface

// File: rtl/image_mem_arbiter.sv
// Two-requester arbiter for the shared image memory: pipelined per-pixel reads,
// with drain + settle around every change of the memory image select.
module image_mem_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int SEL_SETTLE = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  image_mem_arbiter_if.slave   bus,
  output logic [1:0]           dbg_state
);
  typedef enum logic [1:0] {S_GRANT = 2'd0, S_DRAIN = 2'd1, S_SETTLE = 2'd2} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] SETTLE_INI = 4'(SEL_SETTLE - 1);

  state_e              state_q, state_d;
  logic [7:0]          xoff_q, xoff_d, yoff_q, yoff_d;
  logic [1:0]          sel_q, sel_d;
  logic [2:0]          rdata_q, rdata_d;
  logic                drv_q, drv_d, hrv_q, hrv_d;
  logic [3:0]          starve_q, starve_d, settle_q, settle_d;
  logic [RD_LAT-1:0]   tv_q, tv_d, tt_q, tt_d;  // per-stage tag valid / tag-is-hist

  logic       hist_win, disp_win, any_req, sel_match, pipe_empty;
  logic       disp_gnt, hist_gnt;
  logic [1:0] win_sel;

  assign any_req    = bus.disp_req | bus.hist_req;
  assign hist_win   = bus.hist_req & (~bus.disp_req | (starve_q == STARVE_LIM));
  assign disp_win   = bus.disp_req & ~hist_win;
  assign win_sel    = hist_win ? bus.hist_sel : bus.disp_sel;
  // Selects 2 and 3 both mean BACKGROUND, so they never force a reload.
  assign sel_match  = (win_sel == sel_q) | (win_sel[1] & sel_q[1]);
  assign pipe_empty = ~|tv_q;

  always_comb begin
    state_d  = state_q;
    xoff_d   = xoff_q;
    yoff_d   = yoff_q;
    sel_d    = sel_q;
    settle_d = settle_q;
    starve_d = starve_q;
    disp_gnt = 1'b0;
    hist_gnt = 1'b0;
    case (state_q)
      S_GRANT: begin
        if (any_req) begin
          if (sel_match) begin
            disp_gnt = disp_win;
            hist_gnt = hist_win;
            xoff_d   = hist_win ? bus.hist_x : bus.disp_x;
            yoff_d   = hist_win ? bus.hist_y : bus.disp_y;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pipe_empty) begin
          if (any_req) begin
            sel_d    = win_sel;
            settle_d = SETTLE_INI;
            state_d  = S_SETTLE;
          end else begin
            state_d = S_GRANT;
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == 4'd0) state_d = S_GRANT;
        else                  settle_d = settle_q - 4'd1;
      end
      default: state_d = S_GRANT;
    endcase

    if (hist_gnt || !bus.hist_req)                 starve_d = 4'd0;
    else if (disp_gnt && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;

    tv_d[0] = disp_gnt | hist_gnt;
    tt_d[0] = hist_gnt;
    for (int k = 1; k < RD_LAT; k++) begin
      tv_d[k] = tv_q[k-1];
      tt_d[k] = tt_q[k-1];
    end

    // The last tag stage marks the cycle whose mem_pixel belongs to that read.
    rdata_d = tv_q[RD_LAT-1] ? bus.mem_pixel : rdata_q;
    drv_d   = tv_q[RD_LAT-1] & ~tt_q[RD_LAT-1];
    hrv_d   = tv_q[RD_LAT-1] &  tt_q[RD_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_GRANT;
      xoff_q   <= 8'd0;
      yoff_q   <= 8'd0;
      sel_q    <= 2'd2;
      rdata_q  <= 3'd0;
      drv_q    <= 1'b0;
      hrv_q    <= 1'b0;
      starve_q <= 4'd0;
      settle_q <= 4'd0;
      tv_q     <= '0;
      tt_q     <= '0;
    end else begin
      state_q  <= state_d;
      xoff_q   <= xoff_d;
      yoff_q   <= yoff_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
      drv_q    <= drv_d;
      hrv_q    <= hrv_d;
      starve_q <= starve_d;
      settle_q <= settle_d;
      tv_q     <= tv_d;
      tt_q     <= tt_d;
    end
  end

  assign bus.disp_gnt    = disp_gnt;
  assign bus.hist_gnt    = hist_gnt;
  assign bus.disp_rvalid = drv_q;
  assign bus.hist_rvalid = hrv_q;
  assign bus.rdata       = rdata_q;
  assign bus.mem_xoff    = xoff_q;
  assign bus.mem_yoff    = yoff_q;
  assign bus.mem_sel     = sel_q;
  assign bus.settling    = (state_q != S_GRANT);
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_image_mem_arbiter.sv
// Bench for image_mem_arbiter: directed scenarios plus random traffic, checked
// each cycle against a transaction-level model with a read-data scoreboard.
module tb_image_mem_arbiter;
  localparam int RD_LAT     = 3;
  localparam int SEL_SETTLE = 4;
  localparam int STARVE_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  image_mem_arbiter_if ifc();

  image_mem_arbiter #(.RD_LAT(RD_LAT), .SEL_SETTLE(SEL_SETTLE), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [35:0] exp_q[$];  // {due_cycle[31:0], is_hist, pixel[2:0]}

  // model state: mode 0=granting, 1=waiting for reads to finish, 2=settling
  int m_mode, m_starve, m_last, m_resume;
  logic [1:0] m_sel;
  logic [7:0] m_x, m_y;
  int hg_cnt, h_wait, h_wait_max;
  logic d_got = 1'b0, h_got = 1'b0;

  function automatic logic [1:0] norm(input logic [1:0] s);
    return s[1] ? 2'd2 : s;
  endfunction

  function automatic logic [2:0] pix(input logic [1:0] s, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] h;
    h = x + {y[6:0], 1'b0} + y + {6'd0, norm(s)} * 8'd3;
    return h[2:0];
  endfunction

  // Memory model: data appears RD_LAT-1 cycles after the address is presented.
  logic [17:0] a_d1, a_d2;
  always @(posedge clk) begin
    a_d1 <= {ifc.mem_sel, ifc.mem_xoff, ifc.mem_yoff};
    a_d2 <= a_d1;
  end
  assign ifc.mem_pixel = pix(a_d2[17:16], a_d2[15:8], a_d2[7:0]);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sel = 2'd2; m_x = 8'd0; m_y = 8'd0;
    m_starve = 0; m_last = -1000; m_resume = 0;
  endtask

  always @(negedge clk) begin : monitor
    logic hw, dw, eg_d, eg_h;
    logic [1:0] ws;
    logic [35:0] e;
    cyc++;
    d_got = ifc.disp_gnt;
    h_got = ifc.hist_gnt;
    if (ifc.hist_req) begin
      h_wait++;
      if (ifc.hist_gnt) begin
        if (h_wait > h_wait_max) h_wait_max = h_wait;
        h_wait = 0;
        hg_cnt++;
      end
    end else h_wait = 0;
    if (!rst_n) begin
      model_reset();
      exp_q.delete();
      chk("rvalid_in_reset", int'({ifc.disp_rvalid, ifc.hist_rvalid}), 0);
    end else begin
      chk("mem_sel", int'(norm(ifc.mem_sel)), int'(m_sel));
      chk("mem_addr", int'({ifc.mem_xoff, ifc.mem_yoff}), int'({m_x, m_y}));
      chk("settling", int'(ifc.settling), int'(m_mode != 0));
      hw = ifc.hist_req && (!ifc.disp_req || m_starve == STARVE_MAX);
      dw = ifc.disp_req && !hw;
      ws = hw ? ifc.hist_sel : ifc.disp_sel;
      eg_d = 1'b0; eg_h = 1'b0;
      case (m_mode)
        0: if (dw || hw) begin
             if (norm(ws) == m_sel) begin eg_d = dw; eg_h = hw; end
             else m_mode = 1;
           end
        1: if (cyc - m_last > RD_LAT) begin
             if (dw || hw) begin
               m_sel = norm(ws); m_resume = cyc + SEL_SETTLE + 1; m_mode = 2;
             end else m_mode = 0;
           end
        default: if (cyc + 1 >= m_resume) m_mode = 0;
      endcase
      chk("grant", int'({ifc.disp_gnt, ifc.hist_gnt}), int'({eg_d, eg_h}));
      if (eg_d || eg_h) begin
        m_last = cyc;
        m_x = eg_h ? ifc.hist_x : ifc.disp_x;
        m_y = eg_h ? ifc.hist_y : ifc.disp_y;
        exp_q.push_back({32'(cyc + RD_LAT + 1), eg_h, pix(ws, m_x, m_y)});
      end
      if (eg_h || !ifc.hist_req) m_starve = 0;
      else if (eg_d && m_starve < STARVE_MAX) m_starve++;
      if (ifc.disp_rvalid || ifc.hist_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", int'({ifc.disp_rvalid, ifc.hist_rvalid}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_cycle", cyc, int'(e[35:4]));
          chk("rvalid_owner", int'({ifc.disp_rvalid, ifc.hist_rvalid}), e[3] ? 1 : 2);
          chk("rdata", int'(ifc.rdata), int'(e[2:0]));
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][35:4]) <= cyc) begin
        e = exp_q.pop_front();
        chk("rvalid_missing", 0, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_reqs();
    ifc.disp_req = 1'b0; ifc.hist_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_reqs();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mem_sel", int'(ifc.mem_sel), 2);
    chk("rst_settling", int'(ifc.settling), 0);
    chk("rst_addr", int'({ifc.mem_xoff, ifc.mem_yoff}), 0);
    chk("rst_rdata", int'(ifc.rdata), 0);
    chk("rst_state", int'(dbg_state), 0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_step();
    if (!ifc.disp_req || d_got) begin
      if ($urandom_range(0, 99) < 60) begin
        ifc.disp_req = 1'b1; ifc.disp_x = 8'($urandom); ifc.disp_y = 8'($urandom);
        if ($urandom_range(0, 99) < 8) ifc.disp_sel = 2'($urandom_range(0, 3));
      end else ifc.disp_req = 1'b0;
    end else if ($urandom_range(0, 99) < 3) ifc.disp_req = 1'b0;
    if (!ifc.hist_req || h_got) begin
      if ($urandom_range(0, 99) < 50) begin
        ifc.hist_req = 1'b1; ifc.hist_x = 8'($urandom); ifc.hist_y = 8'($urandom);
        if ($urandom_range(0, 99) < 8) ifc.hist_sel = 2'($urandom_range(0, 3));
      end else ifc.hist_req = 1'b0;
    end else if ($urandom_range(0, 99) < 3) ifc.hist_req = 1'b0;
  endtask

  initial begin
    int n, cnt, pulses;
    idle_reqs();
    ifc.disp_x = 8'd0; ifc.disp_y = 8'd0; ifc.disp_sel = 2'd2;
    ifc.hist_x = 8'd0; ifc.hist_y = 8'd0; ifc.hist_sel = 2'd2;
    model_reset();
    hg_cnt = 0; h_wait = 0; h_wait_max = 0;
    tick();
    do_reset();

    // Single display read on the background image.
    ifc.disp_req = 1'b1; ifc.disp_x = 8'd5; ifc.disp_y = 8'd9; ifc.disp_sel = 2'd2;
    @(negedge clk);
    chk("t1_gnt", int'(ifc.disp_gnt), 1);
    tick(); ifc.disp_req = 1'b0;
    @(negedge clk);
    chk("t1_xoff", int'(ifc.mem_xoff), 5);
    chk("t1_yoff", int'(ifc.mem_yoff), 9);
    repeat (RD_LAT) @(negedge clk);
    chk("t1_rvalid", int'(ifc.disp_rvalid), 1);
    chk("t1_rdata", int'(ifc.rdata), int'(pix(2'd2, 8'd5, 8'd9)));

    // Starvation limit: both requesters continuously on the same image.
    repeat (4) tick();
    ifc.disp_req = 1'b1; ifc.hist_req = 1'b1; ifc.disp_sel = 2'd2; ifc.hist_sel = 2'd3;
    hg_cnt = 0; h_wait_max = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (d_got) begin ifc.disp_x = 8'($urandom); ifc.disp_y = 8'($urandom); end
      if (h_got) begin ifc.hist_x = 8'($urandom); ifc.hist_y = 8'($urandom); end
    end
    chk("t2_hist_grants", hg_cnt, 10);
    chk("t2_hist_wait_max", h_wait_max, STARVE_MAX + 1);
    idle_reqs();
    repeat (6) tick();

    // Select change from reset: drain, reload, settle, then grant.
    do_reset();
    ifc.disp_req = 1'b1; ifc.disp_sel = 2'd0; ifc.disp_x = 8'd17; ifc.disp_y = 8'd200;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); n++;
      if (n == 2) chk("t3_settling", int'(ifc.settling), 1);
      if (n == 3) chk("t3_sel", int'(ifc.mem_sel), 0);
      if (ifc.disp_gnt) break;
      tick();
    end
    chk("t3_gnt_cycle", n, SEL_SETTLE + 3);
    tick(); ifc.disp_req = 1'b0;

    // Three hist reads in flight on NEW, then a display request on OLD.
    ifc.hist_req = 1'b1; ifc.hist_sel = 2'd1; ifc.hist_x = 8'd40; ifc.hist_y = 8'd41;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 3; i++) begin
      @(negedge clk);
      if (ifc.hist_gnt) cnt++;
      tick();
      if (cnt == 3) ifc.hist_req = 1'b0;
      else if (h_got) begin ifc.hist_x = 8'($urandom); ifc.hist_y = 8'($urandom); end
    end
    chk("t4_hist_grants", cnt, 3);
    ifc.disp_req = 1'b1; ifc.disp_sel = 2'd0; ifc.disp_x = 8'd77; ifc.disp_y = 8'd3;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.hist_rvalid) begin
        pulses++;
        chk("t4_sel_at_pulse", int'(ifc.mem_sel), 1);
      end
      if (ifc.disp_gnt) break;
      tick();
    end
    chk("t4_pulses", pulses, 3);
    chk("t4_disp_gnt", int'(ifc.disp_gnt), 1);
    tick(); ifc.disp_req = 1'b0;
    repeat (6) tick();

    // Winner needs a select change while the loser already matches.
    do_reset();
    ifc.disp_req = 1'b1; ifc.disp_sel = 2'd1; ifc.disp_x = 8'd1; ifc.disp_y = 8'd2;
    ifc.hist_req = 1'b1; ifc.hist_sel = 2'd2; ifc.hist_x = 8'd3; ifc.hist_y = 8'd4;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifc.disp_gnt || ifc.hist_gnt) break;
      n++;
      tick();
    end
    chk("t5_first_gnt", int'({ifc.disp_gnt, ifc.hist_gnt}), 2);
    tick(); ifc.disp_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifc.hist_gnt) break;
      tick();
    end
    chk("t5_hist_gnt", int'(ifc.hist_gnt), 1);
    tick(); ifc.hist_req = 1'b0;
    repeat (6) tick();

    // Reset with a read in flight, then reset in the middle of settling.
    do_reset();
    ifc.disp_req = 1'b1; ifc.disp_sel = 2'd2; ifc.disp_x = 8'd9; ifc.disp_y = 8'd9;
    @(negedge clk);
    chk("t6_gnt", int'(ifc.disp_gnt), 1);
    tick(); ifc.disp_req = 1'b0;
    do_reset();
    repeat (RD_LAT + 3) tick();
    ifc.disp_req = 1'b1; ifc.disp_sel = 2'd0;
    repeat (4) tick();
    @(negedge clk);
    chk("t6_mid_settle", int'(dbg_state), 2);
    tick();
    do_reset();
    repeat (4) tick();

    // Random traffic with occasional select changes.
    for (int i = 0; i < 3000; i++) begin
      rand_step();
      tick();
    end
    idle_reqs();
    repeat (20) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
